// File: rtl/particle_pkg.sv
// Shared types and constants for the particle fetch path: FSM state encoding
// and the {index, data} beat that travels through the output FIFO.
package particle_pkg;

  localparam int unsigned PARTICLE_ADDR_WIDTH = 7;
  localparam int unsigned PARTICLE_RAM_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PARTICLE_ADDR_WIDTH-1:0] index;
    logic [PARTICLE_RAM_WIDTH-1:0]  data;
  } fetch_beat_t;

endpackage

// File: rtl/particle_fetcher_if.sv
// Bus bundle for the fetcher: RAM read port on one side, valid/ready beat
// stream to the particle updater on the other.
interface particle_fetcher_if #(
  parameter int unsigned ADDR_WIDTH = particle_pkg::PARTICLE_ADDR_WIDTH,
  parameter int unsigned RAM_WIDTH  = particle_pkg::PARTICLE_RAM_WIDTH
);

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read_enable;
  logic [RAM_WIDTH-1:0]  mem_data;
  logic [RAM_WIDTH-1:0]  data_out;
  logic [ADDR_WIDTH-1:0] addr_out;
  logic                  valid_out;
  logic                  ready_in;
  logic                  last_out;

  modport master (
    output mem_addr, mem_read_enable,
    input  mem_data,
    output data_out, addr_out, valid_out, last_out,
    input  ready_in
  );

  modport slave (
    input  mem_addr, mem_read_enable,
    output mem_data,
    input  data_out, addr_out, valid_out, last_out,
    output ready_in
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 23,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign head   = r_mem[r_rd];
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || pop);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= push_data;
        r_wr        <= ptr_next(r_wr);
      end
      if (w_pop) r_rd <= ptr_next(r_rd);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/particle_fetcher.sv
// Streams particle RAM entries 0..count-1 to the updater, using a credit
// scheme so BRAM latency and back-pressure never overflow the output FIFO.
// Optional back-pressure counter: define PARTICLE_FETCHER_STALL_COUNT_EN.
module particle_fetcher
  import particle_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = PARTICLE_ADDR_WIDTH,
  parameter int unsigned RAM_WIDTH    = PARTICLE_RAM_WIDTH,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_WIDTH:0] particle_count,
  output logic                busy,
  output logic                done,
  output logic [15:0]         stall_cycles,
  particle_fetcher_if.master  pf
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W  = ADDR_WIDTH + 1;
  localparam int unsigned BEAT_W = $bits(fetch_beat_t);

  fetch_state_t            r_state;
  logic [IDX_W-1:0]        r_count;
  logic [IDX_W-1:0]        r_ptr;
  logic                    r_mem_re;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [CNT_W-1:0]        r_credits;
  logic                    r_busy;
  logic                    r_done;
  logic [READ_LATENCY-1:0] r_pipe_v;
  logic [ADDR_WIDTH-1:0]   r_pipe_idx [READ_LATENCY];

  logic                    w_valid;
  logic                    w_pop;
  logic                    w_issue;
  logic                    w_can_issue;
  logic                    w_start_ok;
  logic                    w_drained;
  logic [IDX_W-1:0]        w_ptr_inc;
  logic [CNT_W-1:0]        w_credits_avail;
  logic                    w_unused_full;
  logic                    w_fifo_empty;
  logic [CNT_W-1:0]        w_fifo_count;
  fetch_beat_t             w_push_beat;
  fetch_beat_t             w_head;

  // Credits = reads reserved or in flight + FIFO occupancy; capped at FIFO_DEPTH.
  assign w_valid         = !w_fifo_empty;
  assign w_pop           = w_valid && pf.ready_in;
  assign w_credits_avail = r_credits - CNT_W'(w_pop);
  assign w_can_issue     = (w_credits_avail < CNT_W'(FIFO_DEPTH));
  assign w_ptr_inc       = r_ptr + IDX_W'(1);
  assign w_start_ok      = start && (particle_count != '0);
  assign w_issue         = (r_state == IDLE)  ? w_start_ok :
                           (r_state == FETCH) ? w_can_issue : 1'b0;
  assign w_drained       = !r_mem_re && (r_pipe_v == '0) &&
                           (w_fifo_count == CNT_W'(w_pop));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_ptr      <= '0;
      r_mem_re   <= 1'b0;
      r_mem_addr <= '0;
      r_credits  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_mem_re  <= 1'b0;
      r_credits <= w_credits_avail + CNT_W'(w_issue);
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_start_ok) begin
              r_count    <= particle_count;
              r_busy     <= 1'b1;
              r_mem_re   <= 1'b1;
              r_mem_addr <= '0;
              r_ptr      <= IDX_W'(1);
              r_state    <= (particle_count == IDX_W'(1)) ? DRAIN : FETCH;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (w_can_issue) begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= r_ptr[ADDR_WIDTH-1:0];
            r_ptr      <= w_ptr_inc;
            if (w_ptr_inc == r_count) r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_drained) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read-return tracking: valid bit and index ride alongside the RAM latency.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_pipe_v <= '0;
    end else begin
      r_pipe_v[0] <= r_mem_re;
      for (int i = 1; i < int'(READ_LATENCY); i++) r_pipe_v[i] <= r_pipe_v[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_pipe_idx[0] <= r_mem_addr;
    for (int i = 1; i < int'(READ_LATENCY); i++) r_pipe_idx[i] <= r_pipe_idx[i-1];
  end

  always_comb begin
    w_push_beat       = '0;
    w_push_beat.index = PARTICLE_ADDR_WIDTH'(r_pipe_idx[READ_LATENCY-1]);
    w_push_beat.data  = PARTICLE_RAM_WIDTH'(pf.mem_data);
  end

  fetch_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst       (rst),
    .push      (r_pipe_v[READ_LATENCY-1]),
    .pop       (w_pop),
    .push_data (w_push_beat),
    .head      (w_head),
    .full      (w_unused_full),
    .empty     (w_fifo_empty),
    .count     (w_fifo_count)
  );

  assign pf.mem_addr        = r_mem_addr;
  assign pf.mem_read_enable = r_mem_re;
  assign pf.valid_out       = w_valid;
  assign pf.data_out        = RAM_WIDTH'(w_head.data);
  assign pf.addr_out        = ADDR_WIDTH'(w_head.index);
  assign pf.last_out        = w_valid && (IDX_W'(w_head.index) == r_count - IDX_W'(1));
  assign busy               = r_busy;
  assign done               = r_done;

`ifdef PARTICLE_FETCHER_STALL_COUNT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_stall <= '0;
    end else if (w_valid && !pf.ready_in && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cycles = r_stall;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_particle_fetcher.sv
// Directed scoreboard bench for particle_fetcher: one instance at read
// latency 1 for the main scenarios, one at latency 2 for the full 128 pass.
module tb_particle_fetcher;

  localparam int unsigned AW = 7;
  localparam int unsigned RW = 16;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start1, start2;
  logic [CW-1:0] count1, count2;
  logic          busy1, done1, busy2, done2;
  logic [15:0]   stall1, stall2;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  particle_fetcher_if #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW)) if1 ();
  particle_fetcher_if #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW)) if2 ();

  particle_fetcher #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
    .clk_in(clk), .rst(rst), .start(start1), .particle_count(count1),
    .busy(busy1), .done(done1), .stall_cycles(stall1), .pf(if1)
  );

  particle_fetcher #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW), .READ_LATENCY(2), .FIFO_DEPTH(4)) u_dut2 (
    .clk_in(clk), .rst(rst), .start(start2), .particle_count(count2),
    .busy(busy2), .done(done2), .stall_cycles(stall2), .pf(if2)
  );

  // RAM models: latency 1 for dut1, latency 2 for dut2
  logic [RW-1:0] ram [128];
  logic [RW-1:0] m1_q, m2_a, m2_q;

  always @(posedge clk) begin
    if (if1.mem_read_enable) m1_q <= ram[if1.mem_addr];
    if (if2.mem_read_enable) m2_a <= ram[if2.mem_addr];
    m2_q <= m2_a;
  end
  assign if1.mem_data = m1_q;
  assign if2.mem_data = m2_q;

  exp_t sb1[$];
  exp_t sb2[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_pass(input int which, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = AW'(i);
      e.data = ram[i];
      e.last = (i == n - 1);
      if (which == 1) sb1.push_back(e);
      else            sb2.push_back(e);
    end
  endtask

  // Per-pass observations for dut1
  int   start_cyc1, first_cyc1, lastb_cyc1, done_cyc1;
  int   reads1, beats1, valids1, stalls1, max_out1, done_cnt1 = 0;
  logic hold_v1 = 1'b0;
  logic [AW-1:0] hold_a1;
  logic [RW-1:0] hold_d1;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_v1 = 1'b0;
    end else begin
      if (start1 && !busy1) begin
        start_cyc1 = cyc; first_cyc1 = -1; reads1 = 0; beats1 = 0;
        valids1 = 0; stalls1 = 0; max_out1 = 0;
      end
      if (hold_v1) begin
        chk("hold_valid", 32'(if1.valid_out), 1);
        chk("hold_addr", 32'(if1.addr_out), 32'(hold_a1));
        chk("hold_data", 32'(if1.data_out), 32'(hold_d1));
      end
      if (if1.mem_read_enable) begin
        chk("rd1_addr", 32'(if1.mem_addr), reads1);
        reads1++;
      end
      if (reads1 - beats1 > max_out1) max_out1 = reads1 - beats1;
      if (if1.valid_out) valids1++;
      if (if1.valid_out && !if1.ready_in) stalls1++;
      if (if1.valid_out && if1.ready_in) begin
        if (first_cyc1 < 0) first_cyc1 = cyc;
        lastb_cyc1 = cyc;
        beats1++;
        chk("beat1_expected", 32'(sb1.size() != 0), 1);
        if (sb1.size() != 0) begin
          e = sb1.pop_front();
          chk("beat1_idx", 32'(if1.addr_out), 32'(e.idx));
          chk("beat1_data", 32'(if1.data_out), 32'(e.data));
          chk("beat1_last", 32'(if1.last_out), 32'(e.last));
        end
      end
      hold_v1 = if1.valid_out && !if1.ready_in;
      hold_a1 = if1.addr_out;
      hold_d1 = if1.data_out;
      if (done1) begin
        done_cnt1++;
        done_cyc1 = cyc;
      end
    end
  end

  int reads2, beats2, done_cnt2 = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (start2 && !busy2) begin reads2 = 0; beats2 = 0; end
      if (if2.mem_read_enable) begin
        chk("rd2_addr", 32'(if2.mem_addr), reads2);
        reads2++;
      end
      if (if2.valid_out && if2.ready_in) begin
        beats2++;
        chk("beat2_expected", 32'(sb2.size() != 0), 1);
        if (sb2.size() != 0) begin
          e = sb2.pop_front();
          chk("beat2_idx", 32'(if2.addr_out), 32'(e.idx));
          chk("beat2_data", 32'(if2.data_out), 32'(e.data));
          chk("beat2_last", 32'(if2.last_out), 32'(e.last));
        end
      end
      if (done2) done_cnt2++;
    end
  end

  task automatic pulse1(input int n);
    count1 = CW'(n);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int lim);
    int d0;
    bit ok;
    d0 = (which == 1) ? done_cnt1 : done_cnt2;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(posedge clk); #1;
      if (((which == 1) ? done_cnt1 : done_cnt2) != d0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("done_timeout", 32'(ok), 1);
  endtask

  initial begin
    int   d0;
    bit   got;
    logic [3:0] pat;

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; count1 = '0; count2 = '0;
    if1.ready_in = 1'b1; if2.ready_in = 1'b1;
    for (int i = 0; i < 128; i++) ram[i] = RW'(16'h1000 + i);
    repeat (3) @(posedge clk); #1;

    chk("rst_valid", 32'(if1.valid_out), 0);
    chk("rst_mem_re", 32'(if1.mem_read_enable), 0);
    chk("rst_mem_addr", 32'(if1.mem_addr), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_last", 32'(if1.last_out), 0);
    chk("rst_data", 32'(if1.data_out), 0);
    chk("rst_addr", 32'(if1.addr_out), 0);
    chk("rst_stall", 32'(stall1), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // count 5, ready held high
    expect_pass(1, 5);
    pulse1(5);
    chk("t1_busy", 32'(busy1), 1);
    wait_done(1, 100);
    chk("t1_sb_empty", 32'(sb1.size()), 0);
    chk("t1_reads", reads1, 5);
    chk("t1_beats", beats1, 5);
    chk("t1_first_latency", first_cyc1 - start_cyc1, 3);
    chk("t1_burst_span", lastb_cyc1 - first_cyc1, 4);
    chk("t1_done_after_last", done_cyc1 - lastb_cyc1, 1);
    chk("t1_done_width", 32'(done1), 0);
    chk("t1_busy_after", 32'(busy1), 0);

    // count 8, ready pattern 1,0,0,1
    expect_pass(1, 8);
    pat = 4'b1001;
    d0 = done_cnt1;
    got = 1'b0;
    count1 = CW'(8);
    start1 = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if1.ready_in = pat[k % 4];
      if (done_cnt1 != d0) begin got = 1'b1; break; end
    end
    chk("t2_done_timeout", 32'(got), 1);
    if1.ready_in = 1'b1;
    chk("t2_sb_empty", 32'(sb1.size()), 0);
    chk("t2_beats", beats1, 8);
    chk("t2_reads", reads1, 8);
    chk("t2_credit_bound", 32'(max_out1 <= 4), 1);
    chk("t2_saw_stalls", 32'(stalls1 > 0), 1);
    repeat (3) @(posedge clk); #1;
`ifdef PARTICLE_FETCHER_STALL_COUNT_EN
    chk("t2_stall_count", 32'(stall1), stalls1);
`else
    chk("t2_stall_tied", 32'(stall1), 0);
`endif

    // count 0: immediate done, no reads or beats
    pulse1(0);
    wait_done(1, 20);
    chk("t3_reads", reads1, 0);
    chk("t3_valids", valids1, 0);
    chk("t3_done_latency", done_cyc1 - start_cyc1, 1);
    chk("t3_busy", 32'(busy1), 0);

    // reset mid-pass while stalled, then a fresh count-3 pass
    if1.ready_in = 1'b0;
    pulse1(8);
    repeat (6) @(posedge clk); #1;
    chk("t4_stalled_valid", 32'(if1.valid_out), 1);
    d0 = done_cnt1;
    rst = 1'b1;
    sb1.delete();
    @(posedge clk); #1;
    chk("t4_valid", 32'(if1.valid_out), 0);
    chk("t4_mem_re", 32'(if1.mem_read_enable), 0);
    chk("t4_busy", 32'(busy1), 0);
    chk("t4_done", 32'(done1), 0);
    chk("t4_last", 32'(if1.last_out), 0);
    chk("t4_data", 32'(if1.data_out), 0);
    chk("t4_addr", 32'(if1.addr_out), 0);
    chk("t4_stall", 32'(stall1), 0);
    rst = 1'b0;
    if1.ready_in = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("t4_no_done", done_cnt1, d0);
    chk("t4_idle_valid", 32'(if1.valid_out), 0);
    expect_pass(1, 3);
    pulse1(3);
    wait_done(1, 50);
    chk("t4_sb_empty", 32'(sb1.size()), 0);
    chk("t4_beats", beats1, 3);
    chk("t4_reads", reads1, 3);

    // start re-pulsed while busy is ignored
    expect_pass(1, 6);
    d0 = done_cnt1;
    pulse1(6);
    @(posedge clk); #1;
    pulse1(2);
    wait_done(1, 60);
    repeat (5) @(posedge clk); #1;
    chk("t5_beats", beats1, 6);
    chk("t5_reads", reads1, 6);
    chk("t5_sb_empty", 32'(sb1.size()), 0);
    chk("t5_one_done", done_cnt1 - d0, 1);

    // full 128-entry pass at read latency 2
    expect_pass(2, 128);
    count2 = CW'(128);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    wait_done(2, 600);
    chk("t6_reads", reads2, 128);
    chk("t6_beats", beats2, 128);
    chk("t6_sb_empty", 32'(sb2.size()), 0);
    chk("t6_busy", 32'(busy2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/particle_fetcher.md
Name: particle_fetcher

Overview:
- Read-side counterpart of the update buffer path.
- On `start`, walks the particle property RAM from address 0 to `particle_count-1` and streams each entry to the particle updater over a valid/ready interface, tagged with its index.
- Absorbs the fixed BRAM read latency using a credit-limited output FIFO, so downstream back-pressure never drops or duplicates an entry.
- Sits between the particle buffer's read port and the particle updater's input.

Parameters:
- ADDR_WIDTH, 7, particle index / RAM address width (RAM depth 128).
- RAM_WIDTH, 16, width of one particle RAM word.
- READ_LATENCY, 1, cycles from `mem_addr`/`mem_read_enable` to valid `mem_data`; legal values are 1 and 2.
- FIFO_DEPTH, 4, output FIFO entries; must be at least READ_LATENCY+1.

Ports:
- clk_in  input  1  system clock; one clock domain only.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a pass; honoured only when idle.
- particle_count  input  ADDR_WIDTH+1  number of entries to fetch; sampled on accepted `start`.
- mem_addr  output  ADDR_WIDTH  RAM read address.
- mem_read_enable  output  1  RAM read strobe.
- mem_data  input  RAM_WIDTH  RAM read data, READ_LATENCY cycles after the strobe.
- data_out  output  RAM_WIDTH  particle word to the updater.
- addr_out  output  ADDR_WIDTH  index of `data_out`.
- valid_out  output  1  `data_out`/`addr_out` are valid.
- ready_in  input  1  updater accepts; a transfer occurs when `valid_out && ready_in`.
- last_out  output  1  current beat is index `particle_count-1`.
- busy  output  1  pass in progress.
- done  output  1  one-cycle pulse when a pass completes.
- stall_cycles  output  16  back-pressure counter (optional feature).

Behaviour:
- Reset values: all outputs 0, except `busy`=0 and `done`=0. FIFO is empty, in-flight pipeline is cleared, state is IDLE.
- States: IDLE, FETCH, DRAIN.
- IDLE:
  - `start` with `particle_count`>0 → FETCH; latch count; issue pointer = 0; `busy`=1.
  - `start` with `particle_count`=0 → `done` pulses the next cycle; stays IDLE; no reads, no beats.
- FETCH:
  - Issue one read per cycle (`mem_read_enable`=1, `mem_addr`=issue pointer) only when FIFO occupancy + reads in flight < FIFO_DEPTH.
  - Issue pointer increments on each issue.
  - After the read of index count-1 is issued → DRAIN.
- Read return:
  - A shift pipeline of READ_LATENCY valid bits plus index carries each issued read.
  - When the valid bit emerges, {`mem_data`, index} is pushed into the FIFO.
  - The credit rule guarantees the push never overflows.
- Output:
  - `valid_out` = FIFO not empty; `data_out`/`addr_out` come from the FIFO head.
  - `last_out` = `valid_out` && `addr_out` == count-1.
  - Head pops on transfer.
  - First-word latency from `start` is READ_LATENCY+2 cycles.
  - Throughput is 1 beat/cycle with `ready_in` held high.
  - Outputs stay stable while `valid_out && !ready_in`.
- DRAIN: when FIFO is empty and nothing is in flight → IDLE, `busy`=0, `done`=1 for exactly one cycle.
- `start` while `busy` is ignored (no restart, no latch).
- `particle_count`=2^ADDR_WIDTH (128) is legal. The issue pointer is ADDR_WIDTH+1 wide, so there is no wrap before the last index.
- Reset mid-pass: everything clears immediately. Returning RAM data after reset is discarded because the in-flight bits are cleared. No `done` pulse.
- Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.

Optional Feature:
- Macro: PARTICLE_FETCHER_STALL_COUNT_EN.
- Defined:
  - `stall_cycles` counts cycles with `valid_out && !ready_in` during the current pass.
  - Saturates at 16'hFFFF; clears on accepted `start`; holds after `done`.
- Undefined: `stall_cycles` is tied to 0 and no counter logic is generated. The port list is identical in both builds.

Decomposition:
- Package `particle_pkg`:
  - constants PARTICLE_ADDR_WIDTH=7 and PARTICLE_RAM_WIDTH=16;
  - typedef `fetch_state_t` {IDLE, FETCH, DRAIN};
  - packed struct `fetch_beat_t` {index, data}.
- Sub-module `fetch_fifo`:
  - synchronous FIFO, parameterised width/depth;
  - push/pop/full/empty/count;
  - same-cycle push+pop allowed when full.

Test Plan:
- `particle_count`=5, `ready_in`=1, RAM[i]=16'h1000+i → 5 consecutive beats, indices 0..4, data 1000..1004, `last_out` on index 4, `done` one cycle after the final drain, first beat 3 cycles after `start` (READ_LATENCY=1).
- `particle_count`=8, `ready_in` toggling 1,0,0,1,… → no loss or duplication, in-order indices, beat held stable while stalled, occupancy+in-flight never exceeds 4; with macro defined, `stall_cycles` equals the stall count.
- `particle_count`=0 → no `mem_read_enable`, no `valid_out`, `done` pulse one cycle after `start`.
- `particle_count`=128, READ_LATENCY=2 → addresses 0..127 read exactly once, `last_out` at index 127, no wrap.
- `rst` asserted mid-pass with `ready_in`=0 → next cycle all outputs 0; a following `start` with count 3 yields indices 0..2 only.
- `start` re-pulsed while `busy` with a different count → ignored; original pass completes with the original count.
